// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - header bytes, error codes, FSM encoding and timeout sizing for the UART frame parser
package uart_frame_pkg;

  // Frame sync bytes
  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

  // Values driven on o_err_code alongside o_frame_err
  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_HDR1    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  // Idle-gap limit in clock cycles: byte_times * 10 bit-times * clk_hz / baud.
  // Computed in 64 bits because the product overflows 32 bits at high clock rates.
  function automatic int unsigned timeout_cycles(input int unsigned clk_mhz,
                                                 input int unsigned baud,
                                                 input int unsigned bytes);
    longint unsigned cyc;
    cyc = (64'(bytes) * 64'd10 * 64'(clk_mhz) * 64'd1000000) / 64'(baud);
    if (cyc == 64'd0) begin
      cyc = 64'd1;
    end
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - idle-gap counter that pulses o_expire after LIMIT cycles without a clear
module uart_frame_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the expiry cycle suppresses the expiry, so a late byte still wins
  assign o_expire = i_enable && !i_clear && (cnt_q == TERMINAL);

  // Count idle cycles while enabled; restart on clear, disable or expiry
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clear || !i_enable || o_expire) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - hunts AA 55 LEN frames, packs payload into words, flags errors; UART_FRAME_CHECKSUM_EN enables the CHK byte
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FRE       = 50,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned WORD_BYTES    = 2,
  parameter int unsigned MAX_WORDS     = 64,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                    i_clk_sys,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_done,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic                    o_word_last,
  output logic                    o_frame_done,
  output logic                    o_frame_err,
  output logic [1:0]              o_err_code
);

  localparam int unsigned WW       = 8 * WORD_BYTES;
  localparam int unsigned IW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
  localparam logic [7:0] MAX_LEN  = 8'(MAX_WORDS);
  localparam int unsigned TO_CYC   = timeout_cycles(CLK_FRE, BAUD_RATE, TIMEOUT_BYTES);

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic [IW-1:0]   bidx_q, bidx_d;
  logic [WW-1:0]   pack_q, pack_d;
  logic [WW-1:0]   pack_ins;
  logic [WW-1:0]   word_q, word_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            tmr_enable;
  logic            tmr_expire;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign tmr_enable = (state_q != S_HUNT);

  uart_frame_timer #(
    .LIMIT(TO_CYC)
  ) u_timer (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_rst_n),
    .i_clear (i_rx_done),
    .i_enable(tmr_enable),
    .o_expire(tmr_expire)
  );

  // Next-state logic: frame FSM, byte packer, output word handshake and status pulses
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    pack_d   = pack_q;
    word_d   = word_q;
    valid_d  = valid_q && !i_word_ready;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Packer contents with the incoming byte dropped into its lane
    pack_ins = pack_q;
    pack_ins[{bidx_q, 3'b000} +: 8] = i_rx_data;

    if (i_rx_done) begin
      case (state_q)
        S_HUNT: begin
          if (i_rx_data == HDR0) begin
            state_d = S_HDR1;
          end
        end
        S_HDR1: begin
          if (i_rx_data == HDR1) begin
            state_d = S_LEN;
          end else if (i_rx_data != HDR0) begin
            state_d = S_HUNT;
          end
        end
        S_LEN: begin
          if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_LENGTH;
            state_d = S_HUNT;
          end else begin
            len_d   = i_rx_data;
            wcnt_d  = 8'd0;
            bidx_d  = '0;
            state_d = S_PAYLOAD;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_d  = i_rx_data;
`endif
          end
        end
        S_PAYLOAD: begin
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d = csum_q + i_rx_data;
`endif
          if (bidx_q == LAST_IDX) begin
            bidx_d = '0;
            if (valid_q && !i_word_ready) begin
              // Downstream still owns the previous word: keep it, drop the new one
              err_d   = 1'b1;
              code_d  = ERR_OVERFLOW;
              state_d = S_HUNT;
            end else begin
              word_d  = pack_ins;
              valid_d = 1'b1;
              last_d  = ((wcnt_q + 8'd1) == len_q);
              wcnt_d  = wcnt_q + 8'd1;
              if ((wcnt_q + 8'd1) == len_q) begin
`ifdef UART_FRAME_CHECKSUM_EN
                state_d = S_CHK;
`else
                done_d  = 1'b1;
                state_d = S_HUNT;
`endif
              end
            end
          end else begin
            pack_d = pack_ins;
            bidx_d = bidx_q + IW'(1);
          end
        end
        S_CHK: begin
`ifdef UART_FRAME_CHECKSUM_EN
          if (i_rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHECKSUM;
          end
`endif
          state_d = S_HUNT;
        end
        default: begin
          state_d = S_HUNT;
        end
      endcase
    end else if (tmr_expire) begin
      // Idle gap too long: abandon the frame and any partial word
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      bidx_d  = '0;
      state_d = S_HUNT;
    end
  end

  // State, packer and registered outputs
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_HUNT;
      len_q   <= 8'd0;
      wcnt_q  <= 8'd0;
      bidx_q  <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bidx_q  <= bidx_d;
      pack_q  <= pack_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // Running 8-bit sum of LEN and payload bytes
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_word_last  = last_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_err_code   = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench with directed and randomized frames for uart_frame_parser
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int WB    = 2;
  localparam int MAXW  = 64;
  localparam int CLKF  = 1;
  localparam int BAUD  = 1000000;
  localparam int TOB   = 4;
  localparam int LIMIT = TOB * 10 * CLKF * 1000000 / BAUD;
  localparam int ST_DONE = 4;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [8*WB-1:0] word;
  logic          word_valid;
  logic          word_ready;
  logic          word_last;
  logic          frame_done;
  logic          frame_err;
  logic [1:0]    err_code;

  logic [8*WB:0] wq[$];
  int            sq[$];
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 0;

  uart_frame_parser #(
    .CLK_FRE      (CLKF),
    .BAUD_RATE    (BAUD),
    .WORD_BYTES   (WB),
    .MAX_WORDS    (MAXW),
    .TIMEOUT_BYTES(TOB)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .o_word      (word),
    .o_word_valid(word_valid),
    .i_word_ready(word_ready),
    .o_word_last (word_last),
    .o_frame_done(frame_done),
    .o_frame_err (frame_err),
    .o_err_code  (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Downstream ready: always / random but never low while a byte strobes / never
  initial begin : ready_drv
    word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: word_ready = 1'b1;
        1: word_ready = rx_done ? 1'b1 : 1'($urandom_range(0, 1));
        default: word_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: accepted words and status pulses against the expectation queues
  initial begin : monitor
    logic [8*WB:0] e;
    int s;
    int obs;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (word_valid && word_ready) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected: got word %0h last %0b, expected none", word, word_last);
          end else begin
            e = wq.pop_front();
            check("word_data", word, e[8*WB-1:0]);
            check("word_last", word_last, e[8*WB]);
          end
        end
        if (frame_done || frame_err) begin
          check("done_err_exclusive", frame_done & frame_err, 0);
          obs = frame_err ? int'(err_code) : ST_DONE;
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL status_unexpected: got status %0d, expected none", obs);
          end else begin
            s = sq.pop_front();
            check("frame_status", obs, s);
          end
        end
      end
    end
  end

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 6)) : g;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the strobe and gap idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic make_payload(input int len, output bq_t p);
    p = {};
    for (int i = 0; i < len * WB; i++) p.push_back(8'($urandom));
  endtask

  // Reference model for a complete frame: words little-endian, sum of LEN and payload
  task automatic send_frame(input logic [7:0] len, input bq_t pay, input logic [7:0] chk_xor, input int gap);
    logic [8*WB-1:0] w;
    logic [7:0] sum;
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      w = '0;
      for (int k = 0; k < WB; k++) w[8*k +: 8] = pay[i*WB + k];
      wq.push_back({(i == int'(len) - 1), w});
    end
    foreach (pay[j]) sum = sum + pay[j];
    sq.push_back((chk_xor == 8'd0 || !CHK_ON) ? ST_DONE : 0);
    send_byte(8'hAA, pick_gap(gap));
    send_byte(8'h55, pick_gap(gap));
    send_byte(len, pick_gap(gap));
    for (int j = 0; j < pay.size(); j++) begin
      if (j == pay.size() - 1 && !CHK_ON) send_byte(pay[j], 0);
      else send_byte(pay[j], pick_gap(gap));
    end
    if (CHK_ON) send_byte(sum ^ chk_xor, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || sq.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, word, 0);
    check({tag, "_valid"}, word_valid, 0);
    check({tag, "_last"}, word_last, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_code"}, err_code, 0);
  endtask

  initial begin : main
    bq_t p;
    int seen, cyc, kind, len, n;
    logic [7:0] b;
    logic [8*WB-1:0] w;

    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Two-word frame, done one cycle after its final byte
    p = {8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(8'd2, p, 8'h00, 2);
    check("t1_done_latency", frame_done, 1);
    wait_drain(200);

    // Same frame with a wrong CHK byte (0x17)
    send_frame(8'd2, p, 8'h01, 2);
    wait_drain(200);

    // Junk, doubled 0xAA, LEN=0 and LEN=65
    sq.push_back(1);
    send_byte(8'h11, 1); send_byte(8'hAA, 1); send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h00, 0);
    check("t3_len0_err", frame_err, 1);
    check("t3_len0_code", err_code, 1);
    sq.push_back(1);
    send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'd65, 0);
    check("t3_len65_err", frame_err, 1);
    check("t3_len65_code", err_code, 1);
    wait_drain(50);

    // Timeout mid-word, then a normal frame
    sq.push_back(2);
    send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h01, 1); send_byte(8'h34, 0);
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 3 * LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_err) seen = 1;
    end
    check("t4_timeout_seen", seen, 1);
    check("t4_timeout_code", err_code, 2);
    check("t4_timeout_window", (cyc >= LIMIT && cyc <= LIMIT + 1), 1);
    wait_drain(50);
    make_payload(2, p);
    send_frame(8'd2, p, 8'h00, 1);
    wait_drain(200);

    // Overflow with downstream stalled
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    wq.push_back({1'b0, 16'h1234});
    sq.push_back(3);
    send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h02, 1);
    send_byte(8'h34, 1); send_byte(8'h12, 1); send_byte(8'h78, 1); send_byte(8'h56, 0);
    check("t5_ovf_err", frame_err, 1);
    check("t5_ovf_code", err_code, 3);
    check("t5_held_word", word, 16'h1234);
    check("t5_held_valid", word_valid, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("t5_still_word", word, 16'h1234);
    check("t5_still_valid", word_valid, 1);
    rdy_mode = 0;
    wait_drain(100);

    // Reset in the middle of a payload
    send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h02, 1); send_byte(8'h34, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // One-word frame: valid latency and (without CHK) immediate done
    wq.push_back({1'b1, 16'hABCD});
    sq.push_back(ST_DONE);
    send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h01, 1); send_byte(8'hCD, 3); send_byte(8'hAB, 0);
    check("t6_valid_latency", word_valid, 1);
    check("t6_word", word, 16'hABCD);
    check("t6_last", word_last, 1);
    check("t6_done", frame_done, CHK_ON ? 0 : 1);
    if (CHK_ON) send_byte(8'(8'h01 + 8'hCD + 8'hAB), 0);
    wait_drain(100);

    // Bytes spaced exactly at the timeout limit must still be accepted
    make_payload(2, p);
    send_frame(8'd2, p, 8'h00, LIMIT - 1);
    wait_drain(200);

    // Largest legal LEN
    make_payload(MAXW, p);
    send_frame(8'(MAXW), p, 8'h00, 0);
    wait_drain(400);

    // Randomized mix with random downstream backpressure
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      len = ($urandom_range(0, 7) == 0) ? MAXW : int'($urandom_range(1, 8));
      if (kind == 9) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
          if (b == 8'hAA) b = 8'h11;
          send_byte(b, pick_gap(-1));
        end
      end
      if (kind <= 5 || kind == 9) begin
        make_payload(len, p);
        send_frame(8'(len), p, 8'h00, -1);
      end else if (kind == 6) begin
        make_payload(len, p);
        send_frame(8'(len), p, 8'($urandom_range(1, 255)), -1);
      end else if (kind == 7) begin
        b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXW + 1, 255));
        sq.push_back(1);
        send_byte(8'hAA, pick_gap(-1)); send_byte(8'h55, pick_gap(-1)); send_byte(b, pick_gap(-1));
      end else begin
        len = $urandom_range(1, 6);
        make_payload(len, p);
        n = $urandom_range(0, len * WB - 1);
        for (int i = 0; i < n / WB; i++) begin
          w = '0;
          for (int k = 0; k < WB; k++) w[8*k +: 8] = p[i*WB + k];
          wq.push_back({1'b0, w});
        end
        sq.push_back(2);
        send_byte(8'hAA, pick_gap(-1)); send_byte(8'h55, pick_gap(-1)); send_byte(8'(len), pick_gap(-1));
        for (int j = 0; j < n; j++) send_byte(p[j], pick_gap(-1));
        repeat (2 * LIMIT + 5) begin @(posedge clk); #1; end
      end
      wait_drain(600);
    end

    rdy_mode = 0;
    wait_drain(600);
    check("end_words_drained", wq.size(), 0);
    check("end_status_drained", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
